sat_chan_sched: RTL and testbench



---
 rtl/sat_chan_sched_pkg.sv | 36 +++
 rtl/sat_chan_sched_cfg_bank.sv | 41 ++++
 rtl/sat_chan_sched.sv | 163 ++++++++++++++++
 tb/tb_sat_chan_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_chan_sched_pkg.sv
// Shared types for the satellite-channel configuration scheduler: opcodes,
// FSM states, field widths and the per-channel configuration record.
package sat_chan_sched_pkg;

    localparam int DOP_W  = 32;
    localparam int CODE_W = 32;
    localparam int GAIN_W = 16;
    localparam int CA_W   = 6;

    typedef enum logic [2:0] {
        OP_DOP        = 3'd0,
        OP_CODE       = 3'd1,
        OP_GAIN       = 3'd2,
        OP_CA         = 3'd3,
        OP_MASK       = 3'd4,
        OP_COMMIT     = 3'd5,
        OP_COMMIT_NOW = 3'd6,
        OP_RSVD       = 3'd7
    } sched_op_e;

    localparam logic [0:0] ST_IDLE_ENC  = 1'b0;
    localparam logic [0:0] ST_ARMED_ENC = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_ARMED = ST_ARMED_ENC
    } sched_state_e;

    typedef struct packed {
        logic [DOP_W-1:0]  dop;
        logic [CODE_W-1:0] code;
        logic [GAIN_W-1:0] gain;
        logic [CA_W-1:0]   ca;
    } chan_cfg_t;

endpackage

// File: rtl/sat_chan_sched_cfg_bank.sv
// One channel's shadow and active configuration; shadow fields are written
// individually, the whole record is copied to active on load.
module sat_chan_cfg_bank
    import sat_chan_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_dop,
    input  logic        we_code,
    input  logic        we_gain,
    input  logic        we_ca,
    input  logic        load,
    input  logic [31:0] wdata,
    output chan_cfg_t   active
);

    chan_cfg_t shadow_q, shadow_d;
    chan_cfg_t active_q, active_d;

    always_comb begin
        shadow_d = shadow_q;
        if (we_dop)  shadow_d.dop  = wdata[DOP_W-1:0];
        if (we_code) shadow_d.code = wdata[CODE_W-1:0];
        if (we_gain) shadow_d.gain = wdata[GAIN_W-1:0];
        if (we_ca)   shadow_d.ca   = wdata[CA_W-1:0];
        active_d = load ? shadow_q : active_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/sat_chan_sched.sv
// Atomic per-sample configuration scheduler for a bank of sat_chan instances.
// Optional late-commit status via SAT_SCHED_LATE_STATUS_EN.
//
// state | meaning
// IDLE  | accepting host commands into shadow registers
// ARMED | commit pending; commands stalled until the apply edge
module sat_chan_sched
    import sat_chan_sched_pkg::*;
#(
    parameter int NUM_CHAN = 12,
    parameter int CHAN_W   = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dv_in,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [CHAN_W-1:0]        cmd_chan,
    input  logic [31:0]              cmd_data,
    output logic [NUM_CHAN*DOP_W-1:0]  dop_freq,
    output logic [NUM_CHAN*CODE_W-1:0] code_freq,
    output logic [NUM_CHAN*GAIN_W-1:0] gain,
    output logic [NUM_CHAN*CA_W-1:0]   ca_sel,
    output logic [31:0]              sample_cnt,
    output logic                     armed,
`ifdef SAT_SCHED_LATE_STATUS_EN
    output logic                     late_err,
    output logic [15:0]              late_cnt,
`endif
    output logic                     apply_pulse
);

    sched_state_e          state_q, state_d;
    logic [31:0]           sample_cnt_q, sample_cnt_d;
    logic [31:0]           t_q, t_d;
    logic                  force_q, force_d;
    logic [NUM_CHAN-1:0]   mask_q, mask_d;
    logic                  pulse_q, pulse_d;
    logic [31:0]           diff;
    logic                  xfer;
    logic                  apply_now;
    sched_op_e             op;

    assign op   = sched_op_e'(cmd_op);
    assign xfer = cmd_valid && (state_q == S_IDLE);

    // Comparing against the post-increment count makes sample T the first
    // one processed with the new configuration.
    always_comb begin
        sample_cnt_d = sample_cnt_q + {31'd0, dv_in};
        diff         = sample_cnt_d - t_q;
        apply_now    = (state_q == S_ARMED) && (force_q || !diff[31]);
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        force_d = force_q;
        mask_d  = mask_q;
        pulse_d = apply_now;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    case (op)
                        OP_MASK: mask_d = cmd_data[NUM_CHAN-1:0];
                        OP_COMMIT: begin
                            t_d     = cmd_data;
                            force_d = 1'b0;
                            state_d = S_ARMED;
                        end
                        OP_COMMIT_NOW: begin
                            force_d = 1'b1;
                            state_d = S_ARMED;
                        end
                        default: ;
                    endcase
                end
            end
            S_ARMED: begin
                if (apply_now) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            t_q          <= '0;
            force_q      <= 1'b0;
            mask_q       <= '0;
            pulse_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            t_q          <= t_d;
            force_q      <= force_d;
            mask_q       <= mask_d;
            pulse_q      <= pulse_d;
        end
    end

`ifdef SAT_SCHED_LATE_STATUS_EN
    logic        late_err_q, late_err_d;
    logic [15:0] late_cnt_q, late_cnt_d;
    logic [31:0] late_diff;

    always_comb begin
        late_diff  = sample_cnt_d - cmd_data;
        late_err_d = late_err_q;
        late_cnt_d = late_cnt_q;
        if (xfer && (op == OP_COMMIT) && !late_diff[31] && (late_diff != 32'd0)) begin
            late_err_d = 1'b1;
            if (late_cnt_q != 16'hFFFF) late_cnt_d = late_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            late_err_q <= 1'b0;
            late_cnt_q <= '0;
        end else begin
            late_err_q <= late_err_d;
            late_cnt_q <= late_cnt_d;
        end
    end

    assign late_err = late_err_q;
    assign late_cnt = late_cnt_q;
`endif

    chan_cfg_t active_cfg [NUM_CHAN];

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        logic sel;
        assign sel = xfer && (cmd_chan == CHAN_W'(i));

        sat_chan_cfg_bank u_bank (
            .clk     (clk),
            .reset   (reset),
            .we_dop  (sel && (op == OP_DOP)),
            .we_code (sel && (op == OP_CODE)),
            .we_gain (sel && (op == OP_GAIN)),
            .we_ca   (sel && (op == OP_CA)),
            .load    (apply_now && mask_q[i]),
            .wdata   (cmd_data),
            .active  (active_cfg[i])
        );

        assign dop_freq[DOP_W*i +: DOP_W]    = active_cfg[i].dop;
        assign code_freq[CODE_W*i +: CODE_W] = active_cfg[i].code;
        assign gain[GAIN_W*i +: GAIN_W]      = active_cfg[i].gain;
        assign ca_sel[CA_W*i +: CA_W]        = active_cfg[i].ca;
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign armed       = (state_q == S_ARMED);
    assign sample_cnt  = sample_cnt_q;
    assign apply_pulse = pulse_q;

endmodule

// File: tb/tb_sat_chan_sched.sv
// Scenario bench for sat_chan_sched: expected apply events are queued when a
// commit is issued and checked when apply_pulse appears.
module tb_sat_chan_sched;
    import sat_chan_sched_pkg::*;

    localparam int NC = 12;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            dv_in;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [CW-1:0]   cmd_chan;
    logic [31:0]     cmd_data;
    logic [NC*32-1:0] dop_freq;
    logic [NC*32-1:0] code_freq;
    logic [NC*16-1:0] gain;
    logic [NC*6-1:0]  ca_sel;
    logic [31:0]     sample_cnt;
    logic            armed;
    logic            apply_pulse;
`ifdef SAT_SCHED_LATE_STATUS_EN
    logic            late_err;
    logic [15:0]     late_cnt;
`endif

    typedef struct {
        logic [31:0] cnt;
        int          lat;
        int          ch;
        logic [31:0] dop;
        logic [15:0] gn;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sat_chan_sched #(.NUM_CHAN(NC)) dut (
        .clk         (clk),
        .reset       (reset),
        .dv_in       (dv_in),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_chan    (cmd_chan),
        .cmd_data    (cmd_data),
        .dop_freq    (dop_freq),
        .code_freq   (code_freq),
        .gain        (gain),
        .ca_sel      (ca_sel),
        .sample_cnt  (sample_cnt),
        .armed       (armed),
`ifdef SAT_SCHED_LATE_STATUS_EN
        .late_err    (late_err),
        .late_cnt    (late_cnt),
`endif
        .apply_pulse (apply_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] dop_of(input int ch);
        return dop_freq[32*ch +: 32];
    endfunction

    function automatic logic [15:0] gain_of(input int ch);
        return gain[16*ch +: 16];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        dv_in     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Returns at 1 time unit after the accepting edge.
    task automatic send_cmd(input logic [2:0] op, input int ch, input logic [31:0] data);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cmd_op    = op;
        cmd_chan  = CW'(ch);
        cmd_data  = data;
        cmd_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_timeout: op %0d never accepted, expected acceptance", op);
        end
    endtask

    task automatic await_apply(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (apply_pulse) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", cmd_ready); end
        n_checks++; if (armed !== 1'b0) begin n_fail++; $display("FAIL rst_armed: got %b expected 0", armed); end
        n_checks++; if (apply_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse: got %b expected 0", apply_pulse); end
        n_checks++; if (sample_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", sample_cnt); end
        n_checks++; if ((dop_freq | code_freq) !== '0 || gain !== '0 || ca_sel !== '0) begin
            n_fail++; $display("FAIL rst_active: active outputs nonzero, expected all 0");
        end
`ifdef SAT_SCHED_LATE_STATUS_EN
        n_checks++; if (late_err !== 1'b0 || late_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_late: got %b/%0d expected 0/0", late_err, late_cnt);
        end
`endif
    endtask

    task automatic check_apply(input string tag, input int n, input bit seen);
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL %s_timeout: no apply_pulse, expected one", tag);
            return;
        end
        n_checks++; if (sample_cnt !== e.cnt) begin n_fail++; $display("FAIL %s_cnt: got %h expected %h", tag, sample_cnt, e.cnt); end
        if (e.lat >= 0) begin
            n_checks++; if (n != e.lat) begin n_fail++; $display("FAIL %s_lat: got %0d expected %0d", tag, n, e.lat); end
        end
        n_checks++; if (dop_of(e.ch) !== e.dop) begin n_fail++; $display("FAIL %s_dop: got %h expected %h", tag, dop_of(e.ch), e.dop); end
        n_checks++; if (gain_of(e.ch) !== e.gn) begin n_fail++; $display("FAIL %s_gain: got %h expected %h", tag, gain_of(e.ch), e.gn); end
        n_checks++; if (cmd_ready !== 1'b1 || armed !== 1'b0) begin
            n_fail++; $display("FAIL %s_idle: got ready=%b armed=%b expected 1/0", tag, cmd_ready, armed);
        end
    endtask

    task automatic test_commit_timed();
        int n; bit seen;
        do_reset();
        send_cmd(3'(OP_DOP), 0, 32'h0100_0000);
        send_cmd(3'(OP_MASK), 0, 32'h1);
        send_cmd(3'(OP_COMMIT), 0, 32'd10);
        sb.push_back('{cnt: 32'd10, lat: 1, ch: 0, dop: 32'h0100_0000, gn: 16'h0});
        dv_in = 1'b1;
        n_checks++; if (cmd_ready !== 1'b0 || armed !== 1'b1) begin
            n_fail++; $display("FAIL t1_armed: got ready=%b armed=%b expected 0/1", cmd_ready, armed);
        end
        repeat (9) @(posedge clk);
        #1;
        n_checks++; if (sample_cnt !== 32'd9 || dop_of(0) !== 32'd0 || apply_pulse !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL t1_before: got cnt=%0d dop=%h pulse=%b ready=%b expected 9/0/0/0",
                               sample_cnt, dop_of(0), apply_pulse, cmd_ready);
        end
        await_apply(n, seen);
        check_apply("t1", n, seen);
        @(posedge clk); #1;
        n_checks++; if (apply_pulse !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_width: got %b expected 0", apply_pulse); end
`ifdef SAT_SCHED_LATE_STATUS_EN
        n_checks++; if (late_err !== 1'b0) begin n_fail++; $display("FAIL t1_late: got %b expected 0", late_err); end
`endif
        dv_in = 1'b0;
    endtask

    task automatic test_late_commit();
        int n; bit seen;
        do_reset();
        dv_in = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        dv_in = 1'b0;
        n_checks++; if (sample_cnt !== 32'd100) begin n_fail++; $display("FAIL t2_cnt100: got %0d expected 100", sample_cnt); end
        send_cmd(3'(OP_DOP), 3, 32'h0000_ABCD);
        send_cmd(3'(OP_MASK), 0, 32'h8);
        send_cmd(3'(OP_COMMIT), 0, 32'd50);
        sb.push_back('{cnt: 32'd100, lat: 1, ch: 3, dop: 32'h0000_ABCD, gn: 16'h0});
        await_apply(n, seen);
        check_apply("t2", n, seen);
`ifdef SAT_SCHED_LATE_STATUS_EN
        n_checks++; if (late_err !== 1'b1 || late_cnt !== 16'd1) begin
            n_fail++; $display("FAIL t2_late: got %b/%0d expected 1/1", late_err, late_cnt);
        end
`endif
    endtask

    task automatic test_mask_and_stall();
        int n; bit seen;
        do_reset();
        send_cmd(3'(OP_DOP), 1, 32'h0000_0111);
        send_cmd(3'(OP_DOP), 2, 32'h0000_0222);
        send_cmd(3'(OP_MASK), 0, 32'h2);
        send_cmd(3'(OP_COMMIT_NOW), 0, 32'h0);
        sb.push_back('{cnt: 32'd0, lat: -1, ch: 1, dop: 32'h0000_0111, gn: 16'h0});
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL t3_stall: got %b expected 0", cmd_ready); end
        cmd_op    = 3'(OP_GAIN);
        cmd_chan  = CW'(1);
        cmd_data  = 32'h0000_0055;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check_apply("t3", 1, apply_pulse);
        n_checks++; if (dop_of(2) !== 32'd0) begin n_fail++; $display("FAIL t3_ch2: got %h expected 0", dop_of(2)); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++; if (apply_pulse !== 1'b0 || gain_of(1) !== 16'd0) begin
            n_fail++; $display("FAIL t3_held: got pulse=%b gain1=%h expected 0/0", apply_pulse, gain_of(1));
        end
        send_cmd(3'(OP_COMMIT_NOW), 0, 32'h0);
        sb.push_back('{cnt: 32'd0, lat: 1, ch: 1, dop: 32'h0000_0111, gn: 16'h0055});
        await_apply(n, seen);
        check_apply("t3b", n, seen);
        n_checks++; if (dop_of(2) !== 32'd0) begin n_fail++; $display("FAIL t3b_ch2: got %h expected 0", dop_of(2)); end
    endtask

    task automatic test_wrap();
        int n; bit seen;
        do_reset();
        @(negedge clk);
        force dut.sample_cnt_q = 32'hFFFF_FFF0;
        @(posedge clk); #1;
        release dut.sample_cnt_q;
        n_checks++; if (sample_cnt !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL t4_preset: got %h expected fffffff0", sample_cnt); end
        send_cmd(3'(OP_DOP), 0, 32'h0000_CAFE);
        send_cmd(3'(OP_MASK), 0, 32'h1);
        send_cmd(3'(OP_COMMIT), 0, 32'h0000_0004);
        sb.push_back('{cnt: 32'd4, lat: 20, ch: 0, dop: 32'h0000_CAFE, gn: 16'h0});
        dv_in = 1'b1;
        n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL t4_armed: got %b expected 1", armed); end
        await_apply(n, seen);
        check_apply("t4", n, seen);
        dv_in = 1'b0;
    endtask

    task automatic test_reset_armed();
        int n; bit seen;
        do_reset();
        send_cmd(3'(OP_DOP), 0, 32'd5);
        send_cmd(3'(OP_MASK), 0, 32'h1);
        send_cmd(3'(OP_COMMIT_NOW), 0, 32'h0);
        sb.push_back('{cnt: 32'd0, lat: 1, ch: 0, dop: 32'd5, gn: 16'h0});
        await_apply(n, seen);
        check_apply("t5", n, seen);
        send_cmd(3'(OP_COMMIT), 0, 32'h0000_1000);
        dv_in = 1'b1;
        n_checks++; if (armed !== 1'b1) begin n_fail++; $display("FAIL t5_armed: got %b expected 1", armed); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (armed !== 1'b0 || apply_pulse !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL t5_after: got armed=%b pulse=%b ready=%b expected 0/0/1", armed, apply_pulse, cmd_ready);
        end
        n_checks++; if (dop_freq !== '0 || sample_cnt !== 32'd0) begin
            n_fail++; $display("FAIL t5_clear: got dop0=%h cnt=%h expected 0/0", dop_of(0), sample_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++; if (apply_pulse !== 1'b0 || armed !== 1'b0) begin
                n_fail++; $display("FAIL t5_quiet: got pulse=%b armed=%b expected 0/0", apply_pulse, armed);
            end
        end
        dv_in = 1'b0;
    endtask

    task automatic test_out_of_range();
        int n; bit seen;
        do_reset();
        send_cmd(3'(OP_GAIN), NC, 32'h0000_7777);
        send_cmd(3'(OP_RSVD), 0, 32'hFFFF_FFFF);
        send_cmd(3'(OP_MASK), 0, 32'h0000_0FFF);
        send_cmd(3'(OP_COMMIT_NOW), 0, 32'h0);
        sb.push_back('{cnt: 32'd0, lat: 1, ch: 0, dop: 32'd0, gn: 16'h0});
        await_apply(n, seen);
        check_apply("t6", n, seen);
        n_checks++; if (gain !== '0 || dop_freq !== '0) begin
            n_fail++; $display("FAIL t6_gain: got gain0=%h gain11=%h expected 0/0", gain_of(0), gain_of(NC-1));
        end
    endtask

    initial begin
        reset     = 1'b1;
        dv_in     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_chan  = '0;
        cmd_data  = '0;
        test_reset();
        test_commit_timed();
        test_late_commit();
        test_mask_and_stall();
        test_wrap();
        test_reset_armed();
        test_out_of_range();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
